// File: rtl/sobel_pkg.sv
// Shared encodings, latency and width helper
// for the Sobel edge filter.
package sobel_pkg;

   localparam int LATENCY = 4;

   typedef enum logic [1:0] {
      MODE_BIN     = 2'd0,
      MODE_BIN_INV = 2'd1,
      MODE_MAG     = 2'd2,
      MODE_BYPASS  = 2'd3
   } mode_t;

   function automatic int mag_w(input int data_w);
      return data_w + 3;
   endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two-row line store, rows packed side by side,
// registered read that returns pre-write data.
module sobel_line_buf
   import sobel_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1024,
   parameter int AW     = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [2*DATA_W-1:0]   wdata,
   input  logic [AW-1:0]         raddr,
   output logic [2*DATA_W-1:0]   rdata
);

   logic [2*DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel |Gx|+|Gy| filter with
// per-frame shadow config and line-overflow flag.
module sobel_edge_filter
   import sobel_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int LINE_MAX   = 1024,
   parameter int OUT_W      = 16,
   parameter int THRESH_DEF = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_vsync,
   input  logic               in_href,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [1:0]         cfg_mode,
   input  logic [DATA_W+2:0]  cfg_threshold,
   output logic               out_vsync,
   output logic               out_href,
   output logic               out_valid,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_edge,
   output logic               line_ovf
);

   localparam int MW = mag_w(DATA_W);
   localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
   localparam int CW = $clog2(LINE_MAX + 1);
   localparam logic [CW-1:0] COL_MAX = CW'(LINE_MAX);
   localparam logic [CW-1:0] COL_ONE = CW'(1);
   localparam logic [CW-1:0] COL_TWO = CW'(2);
   localparam logic [MW-1:0] PIX_MAX = MW'((1 << DATA_W) - 1);
   localparam logic [OUT_W-1:0] ONES = '1;

   function automatic logic signed [MW-1:0] tap3(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] c
   );
      return signed'(MW'(a) + (MW'(b) << 1) + MW'(c));
   endfunction

   logic              vs_q;
   logic              hr_q;
   logic              armed;
   logic              vs_rise;
   logic              hr_rise;
   logic              hr_fall;
   logic              px;
   logic [CW-1:0]     col;
   logic [CW-1:0]     cur_col;
   logic [1:0]        row;
   mode_t             mode_s;
   logic [MW-1:0]     thr_s;

   assign vs_rise = in_vsync & ~vs_q;
   assign hr_rise = in_href & ~hr_q;
   assign hr_fall = ~in_href & hr_q;
   assign cur_col = hr_rise ? '0 : col;
   assign px      = in_valid & armed;

   // armed stays low after reset until a frame start is seen
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q     <= 1'b0;
         hr_q     <= 1'b0;
         armed    <= 1'b0;
         col      <= '0;
         row      <= '0;
         mode_s   <= MODE_BIN;
         thr_s    <= MW'(THRESH_DEF);
         line_ovf <= 1'b0;
      end else begin
         vs_q <= in_vsync;
         hr_q <= in_href;
         if (vs_rise) begin
            armed  <= 1'b1;
            mode_s <= mode_t'(cfg_mode);
            thr_s  <= cfg_threshold;
         end
         if (vs_rise) begin
            row <= '0;
         end else if (hr_fall && row != 2'd2) begin
            row <= row + 2'd1;
         end
         if (px) begin
            col <= (cur_col == COL_MAX) ? COL_MAX
                                        : cur_col + COL_ONE;
         end else if (hr_rise) begin
            col <= '0;
         end
         if (vs_rise) begin
            line_ovf <= 1'b0;
         end else if (px && cur_col == COL_MAX) begin
            line_ovf <= 1'b1;
         end
      end
   end

   logic              s1_v;
   logic              s1_ovf;
   logic              s1_bord;
   logic [DATA_W-1:0] s1_d;
   logic [AW-1:0]     s1_a;
   mode_t             s1_mode;
   logic [MW-1:0]     s1_thr;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_ovf  <= 1'b0;
         s1_bord <= 1'b0;
         s1_d    <= '0;
         s1_a    <= '0;
         s1_mode <= MODE_BIN;
         s1_thr  <= '0;
      end else begin
         s1_v    <= px;
         s1_ovf  <= (cur_col == COL_MAX);
         s1_bord <= (row < 2'd2) || (cur_col < COL_TWO);
         s1_d    <= in_data;
         s1_a    <= cur_col[AW-1:0];
         s1_mode <= mode_s;
         s1_thr  <= thr_s;
      end
   end

   logic [2*DATA_W-1:0] rd;
   logic [DATA_W-1:0]   rd_r2;
   logic [DATA_W-1:0]   rd_r1;

   assign rd_r2 = rd[2*DATA_W-1:DATA_W];
   assign rd_r1 = rd[DATA_W-1:0];

   // write-back lags the read by one cycle; row r-1 ages into r-2
   sobel_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (LINE_MAX),
      .AW     (AW)
   ) u_line_buf (
      .clk   (clk),
      .we    (s1_v & ~s1_ovf),
      .waddr (s1_a),
      .wdata ({rd_r1, s1_d}),
      .raddr (cur_col[AW-1:0]),
      .rdata (rd)
   );

   logic [DATA_W-1:0] win [3][3];
   logic              s2_v;
   logic              s2_ovf;
   logic              s2_bord;
   mode_t             s2_mode;
   logic [MW-1:0]     s2_thr;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               win[i][j] <= '0;
            end
         end
         s2_v    <= 1'b0;
         s2_ovf  <= 1'b0;
         s2_bord <= 1'b0;
         s2_mode <= MODE_BIN;
         s2_thr  <= '0;
      end else begin
         s2_v    <= s1_v;
         s2_ovf  <= s1_ovf;
         s2_bord <= s1_bord;
         s2_mode <= s1_mode;
         s2_thr  <= s1_thr;
         if (s1_v) begin
            for (int i = 0; i < 3; i++) begin
               win[i][0] <= win[i][1];
               win[i][1] <= win[i][2];
            end
            win[0][2] <= rd_r2;
            win[1][2] <= rd_r1;
            win[2][2] <= s1_d;
         end
      end
   end

   logic signed [MW-1:0] gx_c;
   logic signed [MW-1:0] gy_c;

   always_comb begin
      gx_c = tap3(win[0][2], win[1][2], win[2][2])
           - tap3(win[0][0], win[1][0], win[2][0]);
      gy_c = tap3(win[2][0], win[2][1], win[2][2])
           - tap3(win[0][0], win[0][1], win[0][2]);
   end

   logic signed [MW-1:0] s3_gx;
   logic signed [MW-1:0] s3_gy;
   logic [DATA_W-1:0]    s3_ctr;
   logic                 s3_v;
   logic                 s3_ovf;
   logic                 s3_bord;
   mode_t                s3_mode;
   logic [MW-1:0]        s3_thr;

   always_ff @(posedge clk) begin
      if (rst) begin
         s3_gx   <= '0;
         s3_gy   <= '0;
         s3_ctr  <= '0;
         s3_v    <= 1'b0;
         s3_ovf  <= 1'b0;
         s3_bord <= 1'b0;
         s3_mode <= MODE_BIN;
         s3_thr  <= '0;
      end else begin
         s3_gx   <= gx_c;
         s3_gy   <= gy_c;
         s3_ctr  <= win[1][1];
         s3_v    <= s2_v;
         s3_ovf  <= s2_ovf;
         s3_bord <= s2_bord;
         s3_mode <= s2_mode;
         s3_thr  <= s2_thr;
      end
   end

   logic [MW-1:0]     abs_x;
   logic [MW-1:0]     abs_y;
   logic [MW-1:0]     mag;
   logic [DATA_W-1:0] clip;
   logic              edge_c;
   logic [OUT_W-1:0]  word;

   always_comb begin
      abs_x  = s3_gx[MW-1] ? $unsigned(-s3_gx) : $unsigned(s3_gx);
      abs_y  = s3_gy[MW-1] ? $unsigned(-s3_gy) : $unsigned(s3_gy);
      mag    = (s3_bord || s3_ovf) ? '0 : abs_x + abs_y;
      clip   = (mag > PIX_MAX) ? PIX_MAX[DATA_W-1:0]
                               : mag[DATA_W-1:0];
      edge_c = (mag > s3_thr);
      word   = '0;
      unique case (1'b1)
         s3_mode == MODE_BIN:     word = edge_c ? ONES : '0;
         s3_mode == MODE_BIN_INV: word = edge_c ? '0 : ONES;
         s3_mode == MODE_MAG:     word = OUT_W'(clip);
         default:                 word = OUT_W'(s3_ctr);
      endcase
      if (s3_ovf) begin
         word = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_edge  <= 1'b0;
      end else begin
         out_valid <= s3_v;
         if (s3_v) begin
            out_data <= word;
            out_edge <= edge_c;
         end
      end
   end

   logic [LATENCY-1:0] vs_d;
   logic [LATENCY-1:0] hr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_d <= '0;
         hr_d <= '0;
      end else begin
         vs_d <= {vs_d[LATENCY-2:0], in_vsync};
         hr_d <= {hr_d[LATENCY-2:0], in_href};
      end
   end

   assign out_vsync = vs_d[LATENCY-1];
   assign out_href  = hr_d[LATENCY-1];

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Directed frames against an image-level Sobel
// model, checked every cycle plus literal pins.
module tb_sobel_edge_filter;

   localparam int DATA_W   = 8;
   localparam int LINE_MAX = 16;
   localparam int OUT_W    = 16;
   localparam int THR_DEF  = 20;

   logic        clk;
   logic        rst;
   logic        in_vsync;
   logic        in_href;
   logic        in_valid;
   logic [7:0]  in_data;
   logic [1:0]  cfg_mode;
   logic [10:0] cfg_threshold;
   logic        out_vsync;
   logic        out_href;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_edge;
   logic        line_ovf;

   sobel_edge_filter #(
      .DATA_W     (DATA_W),
      .LINE_MAX   (LINE_MAX),
      .OUT_W      (OUT_W),
      .THRESH_DEF (THR_DEF)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_vsync      (in_vsync),
      .in_href       (in_href),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .cfg_mode      (cfg_mode),
      .cfg_threshold (cfg_threshold),
      .out_vsync     (out_vsync),
      .out_href      (out_href),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_edge      (out_edge),
      .line_ovf      (line_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int out_cnt = 0;
   int drv_r = 0;
   int drv_c = 0;

   int img   [8][20];
   int res_d [8][20];
   int res_e [8][20];

   bit ring_v   [16];
   bit ring_vs  [16];
   bit ring_hr  [16];
   bit ring_chk [16];
   int ring_d   [16];
   int ring_e   [16];
   int ring_r   [16];
   int ring_c   [16];

   bit armed = 0;
   bit vs_prev = 0;
   int m_mode = 0;
   int m_thr = THR_DEF;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int sobel_mag(input int r, input int c);
      int gx;
      int gy;
      if (r < 2 || c < 2) return 0;
      gx = img[r-2][c] + 2 * img[r-1][c] + img[r][c]
         - img[r-2][c-2] - 2 * img[r-1][c-2] - img[r][c-2];
      gy = img[r][c-2] + 2 * img[r][c-1] + img[r][c]
         - img[r-2][c-2] - 2 * img[r-2][c-1] - img[r-2][c];
      return iabs(gx) + iabs(gy);
   endfunction

   function automatic int pix(input int pat, input int r, input int c);
      case (pat)
         0:       return 128;
         1:       return (c < 4) ? 0 : 255;
         2:       return (c < 4) ? 0 : ((r < 4) ? 5 : 6);
         default: return r * 10 + c * 3;
      endcase
   endfunction

   // model: frame config latched on vsync rise, result from the image
   always @(posedge clk) begin
      int k;
      int m;
      int e;
      int d;
      bit ok;
      bit ovf;
      k = cyc % 16;
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            ring_v[i] = 0;
            ring_vs[i] = 0;
            ring_hr[i] = 0;
            ring_chk[i] = 0;
            ring_d[i] = 0;
            ring_e[i] = 0;
            ring_r[i] = 0;
            ring_c[i] = 0;
         end
         armed = 0;
         vs_prev = 0;
         m_mode = 0;
         m_thr = THR_DEF;
      end else begin
         ring_v[k] = 0;
         ring_vs[k] = in_vsync;
         ring_hr[k] = in_href;
         if (in_vsync && !vs_prev) begin
            armed = 1;
            m_mode = int'(cfg_mode);
            m_thr = int'(cfg_threshold);
         end
         vs_prev = in_vsync;
         if (in_valid && armed) begin
            img[drv_r][drv_c] = int'(in_data);
            ovf = (drv_c >= LINE_MAX);
            m = ovf ? 0 : sobel_mag(drv_r, drv_c);
            e = (m > m_thr) ? 1 : 0;
            ok = 1;
            case (m_mode)
               0: d = e ? 'hFFFF : 0;
               1: d = e ? 0 : 'hFFFF;
               2: d = (m > 255) ? 255 : m;
               default: begin
                  ok = (drv_r >= 1 && drv_c >= 1);
                  d = ok ? img[drv_r-1][drv_c-1] : 0;
               end
            endcase
            if (ovf) begin
               d = 0;
               e = 0;
               ok = 1;
            end
            ring_v[k] = 1;
            ring_d[k] = d;
            ring_e[k] = e;
            ring_chk[k] = ok;
            ring_r[k] = drv_r;
            ring_c[k] = drv_c;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      int k;
      if (cyc >= 4) begin
         k = (cyc - 4) % 16;
         chk("out_valid", out_valid, ring_v[k]);
         chk("out_vsync", out_vsync, ring_vs[k]);
         chk("out_href", out_href, ring_hr[k]);
         if (ring_v[k] && out_valid === 1'b1) begin
            out_cnt++;
            res_d[ring_r[k]][ring_c[k]] = int'(out_data);
            res_e[ring_r[k]][ring_c[k]] = int'(out_edge);
            if (ring_chk[k]) begin
               chk($sformatf("out_data r%0d c%0d", ring_r[k], ring_c[k]),
                   out_data, ring_d[k]);
            end
            chk($sformatf("out_edge r%0d c%0d", ring_r[k], ring_c[k]),
                out_edge, ring_e[k]);
         end
      end
   end

   task automatic frame(input int pat, input int w, input int h,
                        input int gap, input int sw_row,
                        input int rst_row);
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 20; c++) begin
            res_d[r][c] = -1;
            res_e[r][c] = -1;
         end
      end
      out_cnt = 0;
      in_vsync = 1'b1;
      tick;
      tick;
      in_vsync = 1'b0;
      tick;
      tick;
      for (int r = 0; r < h; r++) begin
         if (r == sw_row) cfg_mode = 2'd3;
         in_href = 1'b1;
         for (int c = 0; c < w; c++) begin
            if (r == rst_row && c == 2) begin
               in_valid = 1'b0;
               rst = 1'b1;
               tick;
               tick;
               rst = 1'b0;
               out_cnt = 0;
            end
            drv_r = r;
            drv_c = c;
            in_data = 8'(pix(pat, r, c));
            in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            repeat (gap) tick;
         end
         in_href = 1'b0;
         repeat (3) tick;
      end
      repeat (8) tick;
   endtask

   initial begin
      rst = 1'b1;
      in_vsync = 1'b0;
      in_href = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      cfg_mode = 2'd2;
      cfg_threshold = 11'd20;
      repeat (3) tick;
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst out_edge", out_edge, 0);
      chk("rst line_ovf", line_ovf, 0);
      chk("rst out_vsync", out_vsync, 0);
      chk("rst out_href", out_href, 0);
      rst = 1'b0;
      tick;

      frame(2, 8, 8, 0, -1, -1);
      chk("thr mag20 data", res_d[2][4], 20);
      chk("thr mag20 edge", res_e[2][4], 0);
      chk("thr mag22 data", res_d[4][4], 22);
      chk("thr mag22 edge", res_e[4][4], 1);

      cfg_mode = 2'd0;
      frame(0, 8, 8, 1, -1, -1);
      chk("flat count", out_cnt, 64);
      chk("flat data", res_d[5][5], 0);

      frame(1, 8, 8, 0, -1, -1);
      chk("step m0 edge", res_d[3][4], 'hFFFF);
      chk("step m0 flat", res_d[3][6], 0);
      chk("step m0 border", res_d[1][4], 0);

      cfg_mode = 2'd1;
      frame(1, 8, 8, 0, -1, -1);
      chk("step m1 edge", res_d[3][4], 0);
      chk("step m1 flat", res_d[3][6], 'hFFFF);

      cfg_mode = 2'd2;
      frame(1, 8, 8, 0, -1, -1);
      chk("step m2 clip", res_d[3][5], 'hFF);

      cfg_threshold = 11'd1020;
      frame(1, 8, 8, 0, -1, -1);
      chk("thr1020 edge", res_e[3][4], 0);
      chk("thr1020 data", res_d[3][4], 'hFF);

      cfg_threshold = 11'd20;
      cfg_mode = 2'd0;
      frame(3, 8, 8, 0, 4, -1);
      chk("midcfg stays m0", res_d[6][3], 'hFFFF);
      frame(3, 8, 8, 0, -1, -1);
      chk("next frame bypass", res_d[6][3], 56);
      chk("bypass edge", res_e[6][3], 1);

      cfg_mode = 2'd1;
      frame(0, 20, 1, 0, -1, -1);
      chk("ovf count", out_cnt, 20);
      chk("ovf in-range", res_d[0][5], 'hFFFF);
      chk("ovf data", res_d[0][17], 0);
      chk("ovf edge", res_e[0][17], 0);
      chk("ovf flag set", line_ovf, 1);
      frame(0, 4, 1, 0, -1, -1);
      chk("ovf flag cleared", line_ovf, 0);

      cfg_mode = 2'd0;
      frame(1, 8, 8, 0, -1, 3);
      chk("rst silent count", out_cnt, 0);
      frame(1, 8, 8, 0, -1, -1);
      chk("recover count", out_cnt, 64);
      chk("recover edge", res_d[3][4], 'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
